if_id_skid_reg: RTL

Parametrised IF/ID pipeline register with a two-entry elastic (skid) buffer. It sits between instruction fetch and decode and replaces the single-register stall latch with a valid/ready handshake, a flush path that injects NOP bubbles, and a saturating stall-cycle counter. Fetch can keep a request in flight for one cycle after decode stalls without losing an instruction.

---
 rtl/riscv_pkg.sv | 16 +
 rtl/skid_buf_2.sv | 82 ++++++++
 rtl/if_id_skid_reg.sv | 66 ++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: default widths, the canonical NOP and the
// fetch packet carried between fetch and decode.
package riscv_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ILEN = 32;

  // addi x0, x0, 0
  localparam logic [ILEN-1:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
  } fetch_pkt_t;

endpackage

// File: rtl/skid_buf_2.sv
// Generic two-entry elastic buffer: registered in_ready/out_valid/out_data,
// synchronous flush, and an idle payload shown whenever the main entry is empty.
module skid_buf_2 #(
  parameter int unsigned    W         = 64,
  parameter logic [W-1:0]   IDLE_DATA = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t       state;
  logic [W-1:0] skid_data;
  logic         in_fire;
  logic         out_fire;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // out_data doubles as the main entry; it is parked at IDLE_DATA while empty.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state     <= ST_EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      out_data  <= IDLE_DATA;
      skid_data <= IDLE_DATA;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (in_fire) begin
            out_data  <= in_data;
            out_valid <= 1'b1;
            state     <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            out_data <= in_data;
          end else if (in_fire) begin
            skid_data <= in_data;
            in_ready  <= 1'b0;
            state     <= ST_TWO;
          end else if (out_fire) begin
            out_data  <= IDLE_DATA;
            out_valid <= 1'b0;
            state     <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          // in_ready is low here, so only the drain path exists.
          if (out_fire) begin
            out_data  <= skid_data;
            skid_data <= IDLE_DATA;
            in_ready  <= 1'b1;
            state     <= ST_ONE;
          end
        end
        default: begin
          state     <= ST_EMPTY;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          out_data  <= IDLE_DATA;
          skid_data <= IDLE_DATA;
        end
      endcase
    end
  end

endmodule

// File: rtl/if_id_skid_reg.sv
// IF/ID pipeline register on a two-entry skid buffer, with flush to NOP bubbles
// and a saturating count of cycles where decode stalls on a valid instruction.
module if_id_skid_reg #(
  parameter int unsigned     XLEN     = riscv_pkg::XLEN,
  parameter int unsigned     ILEN     = riscv_pkg::ILEN,
  parameter logic [ILEN-1:0] NOP_INST = ILEN'(riscv_pkg::NOP_INST),
  parameter int unsigned     CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ILEN-1:0]  inst_encoding,
  input  logic [XLEN-1:0]  pc,
  input  logic             stall_cs,
  input  logic             flush,
  output logic             o_valid,
  output logic [ILEN-1:0]  o_inst_encoding,
  output logic [XLEN-1:0]  o_pc,
  output logic [CNT_W-1:0] o_stall_cnt
);

  localparam int unsigned PKT_W = XLEN + ILEN;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
  } pkt_t;

  localparam logic [PKT_W-1:0] IDLE_PKT = {XLEN'(0), NOP_INST};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  pkt_t in_pkt;
  pkt_t out_pkt;

  assign in_pkt.pc   = pc;
  assign in_pkt.inst = inst_encoding;

  skid_buf_2 #(
    .W         (PKT_W),
    .IDLE_DATA (IDLE_PKT)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_pkt),
    .out_ready (~stall_cs),
    .out_valid (o_valid),
    .out_data  (out_pkt)
  );

  assign o_pc            = out_pkt.pc;
  assign o_inst_encoding = out_pkt.inst;

  // Survives flush so stall statistics span branch redirects.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_stall_cnt <= '0;
    end else if (o_valid && stall_cs && (o_stall_cnt != CNT_MAX)) begin
      o_stall_cnt <= o_stall_cnt + CNT_W'(1);
    end
  end

endmodule
